data_peak_stage3_detector: RTL and testbench



---
 rtl/data_peak_stage3_detector_pkg.sv | 13 +
 rtl/data_peak_stage3_detector_tracker.sv | 69 ++++++
 rtl/data_peak_stage3_detector.sv | 112 +++++++++++
 tb/tb_data_peak_stage3_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_peak_stage3_detector_pkg.sv
// Shared definitions for the stage-3 peak detector: state encoding and record constants.
package data_peak_stage3_detector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    REPORT = 2'd2
  } stateT;

  localparam int RECORD_LEN_DEF = 64;
  localparam int BASE_CNT       = 4;

endpackage

// File: rtl/data_peak_stage3_detector_tracker.sv
// Per-record max/index/above-threshold accumulator, cleared at record start.
// PEAK_BASELINE_EN: the first BASE_CNT samples form a baseline subtracted from later samples.
module data_peak_tracker
  import data_peak_stage3_detector_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             sampleStb,
  input  logic [IDX_W-1:0] sampleIdx,
  input  logic [7:0]       sample,
  input  logic [7:0]       thr,
  output logic [7:0]       maxVal,
  output logic [IDX_W-1:0] maxIdx,
  output logic [IDX_W:0]   aboveCnt
);

  logic [7:0] level;
  logic       evalEn;
  logic       firstEval;

`ifdef PEAK_BASELINE_EN
  logic [9:0] baseSum;
  logic [7:0] baseline;

  assign baseline  = baseSum[9:2];
  assign level     = (sample > baseline) ? sample - baseline : 8'd0;
  assign evalEn    = sampleIdx >= IDX_W'(BASE_CNT);
  assign firstEval = sampleIdx == IDX_W'(BASE_CNT);

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      baseSum <= '0;
    end else if (clr) begin
      baseSum <= '0;
    end else if (sampleStb && !evalEn) begin
      baseSum <= baseSum + {2'b00, sample};
    end
  end
`else
  assign level     = sample;
  assign evalEn    = 1'b1;
  assign firstEval = sampleIdx == '0;
`endif

  // Strict compare keeps the first occurrence of a tied maximum.
  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      maxVal   <= '0;
      maxIdx   <= '0;
      aboveCnt <= '0;
    end else if (clr) begin
      maxVal   <= '0;
      maxIdx   <= '0;
      aboveCnt <= '0;
    end else if (sampleStb && evalEn) begin
      if (firstEval || (level > maxVal)) begin
        maxVal <= level;
        maxIdx <= sampleIdx;
      end
      if (level > thr) begin
        aboveCnt <= aboveCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_peak_stage3_detector.sv
// Stage-3 consumer: drains one record from the stage-2 buffer and reports peak/index/above-count.
// Optional macro PEAK_BASELINE_EN enables baseline subtraction inside the tracker.
//
// state  | meaning
// IDLE   | waiting for DataAvailable; no requests issued
// READ   | requesting bytes and accumulating samples until RECORD_LEN received
// REPORT | summary presented with PeakValid until PeakReady
module data_peak_stage3_detector
  import data_peak_stage3_detector_pkg::*;
#(
  parameter int RECORD_LEN = RECORD_LEN_DEF,
  parameter int IDX_W      = 6
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             DataAvailable,
  input  logic             DataValid,
  input  logic [7:0]       DataIn,
  output logic             DataRead,
  input  logic [7:0]       Threshold,
  output logic             PeakValid,
  input  logic             PeakReady,
  output logic [7:0]       PeakValue,
  output logic [IDX_W-1:0] PeakIndex,
  output logic [IDX_W:0]   AboveCount,
  output logic             StrayData
);

  localparam logic [IDX_W:0] LEN = (IDX_W + 1)'(RECORD_LEN);

  stateT          state;
  stateT          stateNext;
  logic [IDX_W:0] reqCnt;
  logic [IDX_W:0] reqCntNext;
  logic [IDX_W:0] rxCnt;
  logic [7:0]     thrQ;
  logic           startRec;
  logic           acceptSample;
  logic           dataReadNext;

  always_comb begin
    stateNext    = state;
    startRec     = 1'b0;
    acceptSample = 1'b0;
    case (state)
      IDLE: begin
        if (DataAvailable) begin
          stateNext = READ;
          startRec  = 1'b1;
        end
      end
      READ: begin
        acceptSample = DataValid;
        if (DataValid && (rxCnt == LEN - 1'b1)) begin
          stateNext = REPORT;
        end
      end
      REPORT: begin
        if (PeakReady) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // DataRead is registered, so the request decision uses the post-edge count.
    reqCntNext   = startRec ? '0 : (DataRead ? reqCnt + 1'b1 : reqCnt);
    dataReadNext = (stateNext == READ) && DataAvailable && (reqCntNext < LEN);
  end

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      reqCnt    <= '0;
      rxCnt     <= '0;
      thrQ      <= '0;
      DataRead  <= 1'b0;
      StrayData <= 1'b0;
    end else begin
      state    <= stateNext;
      reqCnt   <= reqCntNext;
      DataRead <= dataReadNext;
      if (startRec) begin
        rxCnt <= '0;
        thrQ  <= Threshold;
      end else if (acceptSample) begin
        rxCnt <= rxCnt + 1'b1;
      end
      if (DataValid && (state != READ)) begin
        StrayData <= 1'b1;
      end
    end
  end

  assign PeakValid = (state == REPORT);

  data_peak_tracker #(
    .IDX_W (IDX_W)
  ) uTracker (
    .SysClk    (SysClk),
    .Reset     (Reset),
    .clr       (startRec),
    .sampleStb (acceptSample),
    .sampleIdx (rxCnt[IDX_W-1:0]),
    .sample    (DataIn),
    .thr       (thrQ),
    .maxVal    (PeakValue),
    .maxIdx    (PeakIndex),
    .aboveCnt  (AboveCount)
  );

endmodule

// File: tb/tb_data_peak_stage3_detector.sv
// Bench for data_peak_stage3_detector: models the stage-2 buffer and checks summaries against a record-level model.
module tb_data_peak_stage3_detector;

  localparam int LEN = 64;
  localparam int IW  = 6;

  logic          SysClk = 1'b0;
  logic          Reset;
  logic          DataAvailable;
  logic          DataValid;
  logic [7:0]    DataIn;
  logic          DataRead;
  logic [7:0]    Threshold;
  logic          PeakValid;
  logic          PeakReady;
  logic [7:0]    PeakValue;
  logic [IW-1:0] PeakIndex;
  logic [IW:0]   AboveCount;
  logic          StrayData;

  int tests = 0;
  int fails = 0;

  logic [7:0] rec [LEN];
  logic [7:0] pending [$];
  int  reqIdx;
  int  readPulses;
  int  rxSeen;
  int  stallAt;
  int  stallLeft;
  bit  jitter;
  bit  availEn;

  always #5 SysClk = ~SysClk;

  data_peak_stage3_detector #(
    .RECORD_LEN (LEN),
    .IDX_W      (IW)
  ) dut (
    .SysClk        (SysClk),
    .Reset         (Reset),
    .DataAvailable (DataAvailable),
    .DataValid     (DataValid),
    .DataIn        (DataIn),
    .DataRead      (DataRead),
    .Threshold     (Threshold),
    .PeakValid     (PeakValid),
    .PeakReady     (PeakReady),
    .PeakValue     (PeakValue),
    .PeakIndex     (PeakIndex),
    .AboveCount    (AboveCount),
    .StrayData     (StrayData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record-level reference: peak of (optionally baseline-corrected) samples, first occurrence wins.
  function automatic void model(input logic [7:0] thr, output int pk, output int ix, output int ab);
    int base;
    int first;
    int v;
    base  = 0;
    first = 0;
`ifdef PEAK_BASELINE_EN
    base  = (int'(rec[0]) + int'(rec[1]) + int'(rec[2]) + int'(rec[3])) / 4;
    first = 4;
`endif
    pk = 0;
    ix = 0;
    ab = 0;
    for (int i = first; i < LEN; i++) begin
      v = (int'(rec[i]) > base) ? int'(rec[i]) - base : 0;
      if ((i == first) || (v > pk)) begin
        pk = v;
        ix = i;
      end
      if (v > int'(thr)) ab++;
    end
  endfunction

  // One clock of the stage-2 buffer: deliver a queued byte, then capture any new request.
  task automatic step();
    @(negedge SysClk);
    if ((pending.size() > 0) && (!jitter || ($urandom_range(1, 0) == 1))) begin
      DataValid = 1'b1;
      DataIn    = pending.pop_front();
      rxSeen++;
    end else begin
      DataValid = 1'b0;
      DataIn    = 8'($urandom);
    end
    if (DataRead) begin
      readPulses++;
      if (reqIdx < LEN) pending.push_back(rec[reqIdx]);
      reqIdx++;
    end
    if (reqIdx > 0) Threshold = 8'($urandom);
    if ((stallLeft > 0) && (reqIdx >= stallAt)) begin
      DataAvailable = 1'b0;
      stallLeft--;
    end else begin
      DataAvailable = availEn && (reqIdx < LEN);
    end
  endtask

  task automatic startRecord(input logic [7:0] thr, input bit jit, input int stall);
    jitter     = jit;
    stallAt    = stall;
    stallLeft  = (stall >= 0) ? 20 : 0;
    reqIdx     = 0;
    readPulses = 0;
    rxSeen     = 0;
    pending.delete();
    Threshold  = thr;
    PeakReady  = 1'b0;
    availEn    = 1'b1;
  endtask

  task automatic runRecord(input string tag, input logic [7:0] thr, input bit jit,
                           input int stall, input int readyDelay);
    int pk, ix, ab, budget;
    model(thr, pk, ix, ab);
    startRecord(thr, jit, stall);
    budget = 0;
    while (!PeakValid && (budget < 3000)) begin
      step();
      budget++;
    end
    chk({tag, "_done"}, 32'(budget < 3000), 1);
    availEn = 1'b0;
    chk({tag, "_value"}, 32'(PeakValue), 32'(pk));
    chk({tag, "_index"}, 32'(PeakIndex), 32'(ix));
    chk({tag, "_above"}, 32'(AboveCount), 32'(ab));
    for (int c = 0; c < readyDelay; c++) begin
      step();
      chk({tag, "_holdvalid"}, 32'(PeakValid), 1);
      chk({tag, "_holdvalue"}, 32'(PeakValue), 32'(pk));
      chk({tag, "_holdindex"}, 32'(PeakIndex), 32'(ix));
      chk({tag, "_holdabove"}, 32'(AboveCount), 32'(ab));
    end
    PeakReady = 1'b1;
    step();
    PeakReady = 1'b0;
    chk({tag, "_released"}, 32'(PeakValid), 0);
    step();
    chk({tag, "_pulses"}, 32'(readPulses), 32'(LEN));
  endtask

  initial begin
    int budget;
    int seenValid;
    Reset         = 1'b1;
    DataAvailable = 1'b0;
    DataValid     = 1'b0;
    DataIn        = 8'd0;
    Threshold     = 8'd0;
    PeakReady     = 1'b0;
    availEn       = 1'b0;
    jitter        = 1'b0;
    stallAt       = -1;
    stallLeft     = 0;
    reqIdx        = 0;
    readPulses    = 0;
    rxSeen        = 0;
    repeat (2) @(negedge SysClk);
    chk("rst_dataread", 32'(DataRead), 0);
    chk("rst_peakvalid", 32'(PeakValid), 0);
    chk("rst_peakvalue", 32'(PeakValue), 0);
    chk("rst_peakindex", 32'(PeakIndex), 0);
    chk("rst_abovecount", 32'(AboveCount), 0);
    chk("rst_stray", 32'(StrayData), 0);
    Reset = 1'b0;
    step();

    for (int i = 0; i < LEN; i++) rec[i] = 8'(i);
    runRecord("ramp", 8'd31, 1'b0, -1, 0);
`ifndef PEAK_BASELINE_EN
    chk("ramp_const_value", 32'(PeakValue), 63);
    chk("ramp_const_index", 32'(PeakIndex), 63);
    chk("ramp_const_above", 32'(AboveCount), 32);
`endif
    chk("no_stray_clean", 32'(StrayData), 0);

    for (int i = 0; i < LEN; i++) rec[i] = 8'd5;
    rec[10] = 8'hC8;
    rec[40] = 8'hC8;
    runRecord("twin", 8'($urandom), 1'b1, -1, 2);
`ifndef PEAK_BASELINE_EN
    chk("twin_const_value", 32'(PeakValue), 200);
    chk("twin_const_index", 32'(PeakIndex), 10);
`endif

    for (int i = 0; i < LEN; i++) rec[i] = 8'($urandom);
    runRecord("stall", 8'($urandom), 1'b0, 30, 7);

    // Abort a ramp record at sample 17 with a reset pulse.
    for (int i = 0; i < LEN; i++) rec[i] = 8'(i);
    startRecord(8'd31, 1'b0, -1);
    budget = 0;
    while ((rxSeen < 17) && (budget < 500)) begin
      step();
      budget++;
    end
    chk("abort_reached", 32'(budget < 500), 1);
    availEn = 1'b0;
    pending.delete();
    Reset = 1'b1;
    step();
    chk("abort_rst_dataread", 32'(DataRead), 0);
    chk("abort_rst_peakvalid", 32'(PeakValid), 0);
    chk("abort_rst_peakvalue", 32'(PeakValue), 0);
    chk("abort_rst_peakindex", 32'(PeakIndex), 0);
    chk("abort_rst_abovecount", 32'(AboveCount), 0);
    chk("abort_rst_stray", 32'(StrayData), 0);
    Reset = 1'b0;
    seenValid = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (PeakValid) seenValid++;
    end
    chk("abort_no_summary", 32'(seenValid), 0);
    runRecord("after_abort", 8'd31, 1'b1, -1, 1);

    // Stray byte while idle.
    @(negedge SysClk);
    DataValid = 1'b1;
    DataIn    = 8'hA5;
    @(negedge SysClk);
    DataValid = 1'b0;
    chk("stray_set", 32'(StrayData), 1);
    chk("stray_no_start", 32'(PeakValid), 0);
    for (int i = 0; i < LEN; i++) rec[i] = 8'($urandom);
    runRecord("post_stray", 8'($urandom), 1'b1, -1, 0);
    chk("stray_sticky", 32'(StrayData), 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LEN; i++) rec[i] = 8'($urandom);
      if (r == 1) rec[LEN-1] = 8'hFF;
      runRecord($sformatf("rand%0d", r), 8'($urandom), 1'(r % 2), -1, r);
    end

`ifdef PEAK_BASELINE_EN
    for (int i = 0; i < 4; i++) rec[i] = 8'd10;
    for (int i = 4; i < LEN; i++) rec[i] = 8'($urandom_range(100, 20));
    rec[37] = 8'd110;
    runRecord("baseline", 8'd50, 1'b1, -1, 0);
    chk("baseline_const_value", 32'(PeakValue), 100);
    chk("baseline_const_index", 32'(PeakIndex), 37);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
